// File: rtl/enable_pipe_pkg.sv
// Shared helpers for the enable_pipe pipeline register.
package enable_pipe_pkg;

  // Width of the occupancy count for a pipe of the given depth (holds 0..depth).
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/enable_pipe_stage.sv
// One valid/data register of enable_pipe. Data is only written when a valid word
// is loaded, so it keeps its last value after the word drains.
// Optional build macro: ENABLE_PIPE_FLUSH_EN adds flush_i, which clears the valid bit.
module enable_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
`ifdef ENABLE_PIPE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  typedef struct packed {
    logic             valid;
    logic [Width-1:0] data;
  } stage_t;

  stage_t st_q, st_d;

  // Next state: load valid always, data only when the loaded word is valid.
  always_comb begin
    st_d = st_q;
    if (load_i) begin
      st_d.valid = valid_i;
      if (valid_i) begin
        st_d.data = data_i;
      end
    end
`ifdef ENABLE_PIPE_FLUSH_EN
    // Flush wins over any load and leaves the data untouched.
    if (flush_i) begin
      st_d.valid = 1'b0;
      st_d.data  = st_q.data;
    end
`endif
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign valid_o = st_q.valid;
  assign data_o  = st_q.data;

endmodule

// File: rtl/enable_pipe.sv
// Multi-stage valid/ready pipeline register with a global enable that freezes it.
// Empty stages pull from their predecessor even while the output is stalled.
// Optional build macro: ENABLE_PIPE_FLUSH_EN adds the synchronous flush input.
module enable_pipe
  import enable_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned OCC_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             enable,
`ifdef ENABLE_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            rdy;
  logic [OCC_W-1:0]            occ;

  // Ready chain from the output side back to the input side.
  always_comb begin
    logic carry;
    carry = out_ready;
    rdy   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      carry  = enable && (!v[i] || carry);
      rdy[i] = carry;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             valid_in;
    logic [WIDTH-1:0] data_in;

    if (g == 0) begin : g_head
      assign valid_in = in_valid;
      assign data_in  = in_data;
    end else begin : g_body
      assign valid_in = v[g-1];
      assign data_in  = d[g-1];
    end

    enable_pipe_stage #(
      .Width (WIDTH)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rstN),
      .load_i  (rdy[g]),
`ifdef ENABLE_PIPE_FLUSH_EN
      .flush_i (flush),
`endif
      .valid_i (valid_in),
      .data_i  (data_in),
      .valid_o (v[g]),
      .data_o  (d[g])
    );
  end

  // Occupancy is a popcount of the registered valid bits only.
  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

`ifdef ENABLE_PIPE_FLUSH_EN
  // Nothing is accepted in a flush cycle since every valid is about to clear.
  assign in_ready = rdy[0] && !flush;
`else
  assign in_ready = rdy[0];
`endif

  // The consumer shares the enable domain, so out_valid may drop while frozen.
  assign out_valid = v[DEPTH-1] && enable;
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;

endmodule
